// File: rtl/csr_commit_ctrl_if.sv
// rtl/csr_commit_ctrl_if.sv - WB-stage retire handshake bundle into the CSR commit controller
interface csr_commit_ctrl_if;
  logic        ws_valid;
  logic        ws_ready;
  logic [31:0] ws_pc;
  logic [2:0]  ws_op;
  logic [13:0] ws_csr_num;
  logic [31:0] ws_rj_value;
  logic [31:0] ws_rkd_value;
  logic [31:0] ws_vaddr;
  logic        ws_ex_adef;
  logic        ws_ex_ine;
  logic        ws_ex_sys;
  logic        ws_ex_brk;
  logic        ws_ex_ale;

  modport master (
    output ws_valid, ws_pc, ws_op, ws_csr_num, ws_rj_value, ws_rkd_value, ws_vaddr,
           ws_ex_adef, ws_ex_ine, ws_ex_sys, ws_ex_brk, ws_ex_ale,
    input  ws_ready
  );

  modport slave (
    input  ws_valid, ws_pc, ws_op, ws_csr_num, ws_rj_value, ws_rkd_value, ws_vaddr,
           ws_ex_adef, ws_ex_ine, ws_ex_sys, ws_ex_brk, ws_ex_ale,
    output ws_ready
  );
endinterface

// File: rtl/csr_commit_ctrl.sv
// rtl/csr_commit_ctrl.sv - writeback CSR commit, exception encode, flush and drain control
module csr_commit_ctrl #(
  parameter int unsigned DRAIN_CYCLES = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  csr_commit_ctrl_if.slave     ws,
  input  logic                 has_int,
  input  logic [31:0]          csr_rdata,
  input  logic [31:0]          era,
  input  logic [31:0]          eentry,
  output logic                 csr_we,
  output logic [13:0]          csr_num,
  output logic [31:0]          csr_wmask,
  output logic [31:0]          csr_wdata,
  output logic                 excp_flush,
  output logic                 ertn_flush,
  output logic [5:0]           ecode,
  output logic [2:0]           esubcode,
  output logic [31:0]          epc,
  output logic [31:0]          eaddr,
  output logic                 rd_valid,
  output logic [31:0]          rd_value,
  output logic                 flush_req,
  output logic [31:0]          flush_pc
);

  localparam logic [3:0] DRAIN_INIT = 4'(DRAIN_CYCLES - 1);

  localparam logic [2:0] OP_CSRRD   = 3'd1;
  localparam logic [2:0] OP_CSRWR   = 3'd2;
  localparam logic [2:0] OP_CSRXCHG = 3'd3;
  localparam logic [2:0] OP_ERTN    = 3'd4;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_COMMIT = 2'd1,
    S_FLUSH  = 2'd2,
    S_DRAIN  = 2'd3
  } state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [2:0]  op;
    logic [13:0] num;
    logic [31:0] rj;
    logic [31:0] rkd;
    logic [31:0] vaddr;
    logic        adef;
    logic        ine;
    logic        sys;
    logic        brk;
    logic        ale;
    logic        int_tag;
  } stage_t;

  state_t      state_q, state_d;
  stage_t      stage_q, stage_d;
  logic        stage_valid_q, stage_valid_d;
  logic [3:0]  drain_cnt_q, drain_cnt_d;
  logic        flush_excp_q, flush_excp_d;

  logic        commit;
  logic        any_ex;
  logic        do_excp;
  logic        do_ertn;
  logic        do_flush;
  logic        ready;
  logic        accept;
  logic        op_rd;
  logic        op_wr;
  stage_t      incoming;

  assign commit   = (state_q == S_COMMIT) && stage_valid_q;
  assign any_ex   = stage_q.int_tag | stage_q.adef | stage_q.ine |
                    stage_q.sys | stage_q.brk | stage_q.ale;
  assign op_rd    = (stage_q.op == OP_CSRRD) || (stage_q.op == OP_CSRWR) ||
                    (stage_q.op == OP_CSRXCHG);
  assign op_wr    = (stage_q.op == OP_CSRWR) || (stage_q.op == OP_CSRXCHG);
  assign do_excp  = commit & any_ex;
  assign do_ertn  = commit & ~any_ex & (stage_q.op == OP_ERTN);
  assign do_flush = do_excp | do_ertn;

  // A flushing instruction holds off the pipe; every other state keeps it flowing
  assign ready       = ~reset & ~do_flush;
  assign ws.ws_ready = ready;
  assign accept      = ws.ws_valid & ready;

  assign incoming = '{
    pc:      ws.ws_pc,
    op:      ws.ws_op,
    num:     ws.ws_csr_num,
    rj:      ws.ws_rj_value,
    rkd:     ws.ws_rkd_value,
    vaddr:   ws.ws_vaddr,
    adef:    ws.ws_ex_adef,
    ine:     ws.ws_ex_ine,
    sys:     ws.ws_ex_sys,
    brk:     ws.ws_ex_brk,
    ale:     ws.ws_ex_ale,
    int_tag: has_int
  };

  // Next-state: stage capture on accept, flush entry, drain countdown
  always_comb begin
    state_d       = state_q;
    stage_d       = stage_q;
    stage_valid_d = stage_valid_q;
    drain_cnt_d   = drain_cnt_q;
    flush_excp_d  = flush_excp_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          stage_d       = incoming;
          stage_valid_d = 1'b1;
          state_d       = S_COMMIT;
        end
      end
      S_COMMIT: begin
        if (do_flush) begin
          stage_valid_d = 1'b0;
          flush_excp_d  = do_excp;
          state_d       = S_FLUSH;
        end else if (accept) begin
          stage_d       = incoming;
          stage_valid_d = 1'b1;
          state_d       = S_COMMIT;
        end else begin
          stage_valid_d = 1'b0;
          state_d       = S_IDLE;
        end
      end
      S_FLUSH: begin
        drain_cnt_d = DRAIN_INIT;
        state_d     = S_DRAIN;
      end
      S_DRAIN: begin
        if (drain_cnt_q == 4'd0) begin
          state_d = S_IDLE;
        end else begin
          drain_cnt_d = drain_cnt_q - 4'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, stage and drain counter registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      stage_q       <= '0;
      stage_valid_q <= 1'b0;
      drain_cnt_q   <= 4'd0;
      flush_excp_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      stage_q       <= stage_d;
      stage_valid_q <= stage_valid_d;
      drain_cnt_q   <= drain_cnt_d;
      flush_excp_q  <= flush_excp_d;
    end
  end

  // Commit-cycle CSR access, exception encode and redirect; held quiet during reset
  always_comb begin
    csr_we     = 1'b0;
    csr_num    = 14'd0;
    csr_wmask  = 32'd0;
    csr_wdata  = 32'd0;
    excp_flush = 1'b0;
    ertn_flush = 1'b0;
    ecode      = 6'd0;
    esubcode   = 3'd0;
    epc        = 32'd0;
    eaddr      = 32'd0;
    rd_valid   = 1'b0;
    rd_value   = 32'd0;
    flush_req  = 1'b0;
    flush_pc   = 32'd0;
    if (!reset) begin
      if (commit) begin
        csr_num   = stage_q.num;
        csr_wdata = stage_q.rkd;
        if (stage_q.op == OP_CSRWR) begin
          csr_wmask = 32'hFFFF_FFFF;
        end else if (stage_q.op == OP_CSRXCHG) begin
          csr_wmask = stage_q.rj;
        end
        if (any_ex) begin
          excp_flush = 1'b1;
          epc        = stage_q.pc;
          eaddr      = stage_q.vaddr;
          if (stage_q.int_tag)   ecode = 6'h00;
          else if (stage_q.adef) ecode = 6'h08;
          else if (stage_q.ine)  ecode = 6'h0D;
          else if (stage_q.sys)  ecode = 6'h0B;
          else if (stage_q.brk)  ecode = 6'h0C;
          else                   ecode = 6'h09;
        end else if (stage_q.op == OP_ERTN) begin
          ertn_flush = 1'b1;
        end else if (op_rd) begin
          rd_valid = 1'b1;
          rd_value = csr_rdata;
          csr_we   = op_wr;
        end
      end
      if (state_q == S_FLUSH) begin
        flush_req = 1'b1;
        flush_pc  = flush_excp_q ? eentry : era;
      end
    end
  end

endmodule

// File: tb/tb_csr_commit_ctrl.sv
// tb/tb_csr_commit_ctrl.sv - scenario and randomized model-based bench for csr_commit_ctrl
module tb_csr_commit_ctrl;

  localparam int D = 2;

  logic        clk;
  logic        reset;
  logic        has_int;
  logic [31:0] csr_rdata, era, eentry;
  logic        csr_we, excp_flush, ertn_flush, rd_valid, flush_req;
  logic [13:0] csr_num;
  logic [31:0] csr_wmask, csr_wdata, epc, eaddr, rd_value, flush_pc;
  logic [5:0]  ecode;
  logic [2:0]  esubcode;

  int vectors = 0;
  int miscompares = 0;

  csr_commit_ctrl_if ws_if ();

  csr_commit_ctrl #(.DRAIN_CYCLES(D)) dut (
    .clk(clk), .reset(reset), .ws(ws_if),
    .has_int(has_int), .csr_rdata(csr_rdata), .era(era), .eentry(eentry),
    .csr_we(csr_we), .csr_num(csr_num), .csr_wmask(csr_wmask), .csr_wdata(csr_wdata),
    .excp_flush(excp_flush), .ertn_flush(ertn_flush), .ecode(ecode), .esubcode(esubcode),
    .epc(epc), .eaddr(eaddr), .rd_valid(rd_valid), .rd_value(rd_value),
    .flush_req(flush_req), .flush_pc(flush_pc)
  );

  wire [219:0] outs_cat = {csr_we, csr_num, csr_wmask, csr_wdata, excp_flush, ertn_flush,
                           ecode, esubcode, epc, eaddr, rd_valid, rd_value, flush_req, flush_pc};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic drive_idle();
    ws_if.ws_valid     = 1'b0;
    ws_if.ws_pc        = '0;
    ws_if.ws_op        = '0;
    ws_if.ws_csr_num   = '0;
    ws_if.ws_rj_value  = '0;
    ws_if.ws_rkd_value = '0;
    ws_if.ws_vaddr     = '0;
    {ws_if.ws_ex_adef, ws_if.ws_ex_ine, ws_if.ws_ex_sys, ws_if.ws_ex_brk, ws_if.ws_ex_ale} = 5'b0;
    has_int = 1'b0;
  endtask

  // ex = {adef, ine, sys, brk, ale}
  task automatic drive_instr(input logic [2:0] op, input logic [13:0] num, input logic [31:0] rj,
                             input logic [31:0] rkd, input logic [31:0] pc, input logic [31:0] va,
                             input logic [4:0] ex, input logic hi);
    ws_if.ws_valid     = 1'b1;
    ws_if.ws_pc        = pc;
    ws_if.ws_op        = op;
    ws_if.ws_csr_num   = num;
    ws_if.ws_rj_value  = rj;
    ws_if.ws_rkd_value = rkd;
    ws_if.ws_vaddr     = va;
    {ws_if.ws_ex_adef, ws_if.ws_ex_ine, ws_if.ws_ex_sys, ws_if.ws_ex_brk, ws_if.ws_ex_ale} = ex;
    has_int = hi;
  endtask

  task automatic settle();
    drive_idle();
    repeat (D + 4) @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive_instr(3'd2, 14'h10, 32'h1, 32'h2, 32'h3, 32'h4, 5'b0, 1'b1);
    csr_rdata = 32'h0; era = 32'h0; eentry = 32'h0;
    repeat (2) @(negedge clk);
    #1;
    vectors++;
    if (outs_cat !== '0 || ws_if.ws_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_outputs got %h ready %b exp 0", outs_cat, ws_if.ws_ready);
    end
    drive_idle();
    reset = 1'b0;
    @(negedge clk); #1;
    vectors++;
    if (outs_cat !== '0 || ws_if.ws_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_release got %h ready %b exp 0 ready 1", outs_cat, ws_if.ws_ready);
    end
  endtask

  task automatic test_csrwr();
    @(negedge clk);
    drive_instr(3'd2, 14'h30, 32'h0, 32'h1234ABCD, 32'h1C000000, 32'h0, 5'b0, 1'b0);
    @(negedge clk);
    drive_idle();
    csr_rdata = 32'h5;
    #1;
    vectors++;
    if ({csr_we, csr_num, csr_wmask, csr_wdata, rd_valid, rd_value} !==
        {1'b1, 14'h30, 32'hFFFFFFFF, 32'h1234ABCD, 1'b1, 32'h5}) begin
      miscompares++;
      $display("FAIL csrwr we=%b num=%h mask=%h wdata=%h rdv=%b rd=%h exp 1 30 ffffffff 1234abcd 1 5",
               csr_we, csr_num, csr_wmask, csr_wdata, rd_valid, rd_value);
    end
    @(negedge clk); #1;
    vectors++;
    if (csr_we !== 1'b0 || rd_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL csrwr_idle we=%b rdv=%b exp 0 0", csr_we, rd_valid);
    end
  endtask

  task automatic test_csrxchg();
    @(negedge clk);
    drive_instr(3'd3, 14'h44, 32'h0000FF00, 32'hAAAAAAAA, 32'h1C000010, 32'h0, 5'b0, 1'b0);
    @(negedge clk);
    drive_idle();
    #1;
    vectors++;
    if ({csr_we, csr_wmask, csr_wdata} !== {1'b1, 32'h0000FF00, 32'hAAAAAAAA}) begin
      miscompares++;
      $display("FAIL csrxchg we=%b mask=%h wdata=%h exp 1 0000ff00 aaaaaaaa", csr_we, csr_wmask, csr_wdata);
    end
    @(negedge clk); #1;
    vectors++;
    if (csr_we !== 1'b0) begin
      miscompares++;
      $display("FAIL csrxchg_one_cycle we=%b exp 0", csr_we);
    end
  endtask

  task automatic test_syscall();
    @(negedge clk);
    eentry = 32'h1C008000;
    drive_instr(3'd0, 14'h0, 32'h0, 32'h0, 32'h1C000100, 32'h0, 5'b00100, 1'b0);
    @(negedge clk);
    drive_idle();
    #1;
    vectors++;
    if ({excp_flush, ecode, esubcode, epc, ws_if.ws_ready} !== {1'b1, 6'h0B, 3'd0, 32'h1C000100, 1'b0}) begin
      miscompares++;
      $display("FAIL syscall ex=%b ecode=%h sub=%h epc=%h ready=%b exp 1 0b 0 1c000100 0",
               excp_flush, ecode, esubcode, epc, ws_if.ws_ready);
    end
    @(negedge clk);
    drive_instr(3'd2, 14'h30, 32'h0, 32'h55, 32'h1C000104, 32'h0, 5'b0, 1'b0);
    #1;
    vectors++;
    if ({flush_req, flush_pc, csr_we} !== {1'b1, 32'h1C008000, 1'b0}) begin
      miscompares++;
      $display("FAIL syscall_redirect req=%b pc=%h we=%b exp 1 1c008000 0", flush_req, flush_pc, csr_we);
    end
    for (int i = 0; i < D + 1; i++) begin
      @(negedge clk); #1;
      vectors++;
      if (csr_we !== 1'b0 || flush_req !== 1'b0) begin
        miscompares++;
        $display("FAIL syscall_drain[%0d] we=%b req=%b exp 0 0", i, csr_we, flush_req);
      end
    end
    @(negedge clk);
    drive_idle();
    #1;
    vectors++;
    if (csr_we !== 1'b1) begin
      miscompares++;
      $display("FAIL syscall_after_drain we=%b exp 1", csr_we);
    end
    settle();
  endtask

  task automatic test_priority();
    for (int hi = 0; hi < 2; hi++) begin
      @(negedge clk);
      drive_instr(3'd2, 14'h30, 32'h0, 32'h9, 32'h1C000200, 32'h1C000203, 5'b10001, hi[0]);
      @(negedge clk);
      drive_idle();
      #1;
      vectors++;
      if ({excp_flush, ecode, csr_we, eaddr} !== {1'b1, (hi != 0) ? 6'h00 : 6'h08, 1'b0, 32'h1C000203}) begin
        miscompares++;
        $display("FAIL priority_int%0d ex=%b ecode=%h we=%b eaddr=%h", hi, excp_flush, ecode, csr_we, eaddr);
      end
      settle();
    end
  endtask

  task automatic test_ertn();
    @(negedge clk);
    drive_instr(3'd4, 14'h0, 32'h0, 32'h0, 32'h1C000300, 32'h0, 5'b0, 1'b0);
    @(negedge clk);
    drive_idle();
    era = 32'h1C000200;
    #1;
    vectors++;
    if ({ertn_flush, excp_flush, ecode, epc} !== {1'b1, 1'b0, 6'h0, 32'h0}) begin
      miscompares++;
      $display("FAIL ertn ertn=%b ex=%b ecode=%h epc=%h exp 1 0 0 0", ertn_flush, excp_flush, ecode, epc);
    end
    @(negedge clk); #1;
    vectors++;
    if ({flush_req, flush_pc} !== {1'b1, 32'h1C000200}) begin
      miscompares++;
      $display("FAIL ertn_redirect req=%b pc=%h exp 1 1c000200", flush_req, flush_pc);
    end
    settle();
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (i < 3) drive_instr(3'd1, 14'(i + 1), 32'h0, 32'h0, 32'h1C000400 + 32'(4 * i), 32'h0, 5'b0, 1'b0);
      else drive_idle();
      csr_rdata = 32'hC0DE0000 + 32'(i);
      #1;
      if (i < 3) begin
        vectors++;
        if (ws_if.ws_ready !== 1'b1) begin
          miscompares++;
          $display("FAIL b2b_ready[%0d] got %b exp 1", i, ws_if.ws_ready);
        end
      end
      if (i > 0) begin
        vectors++;
        if ({rd_valid, rd_value, csr_num} !== {1'b1, 32'hC0DE0000 + 32'(i), 14'(i)}) begin
          miscompares++;
          $display("FAIL b2b_rd[%0d] v=%b val=%h num=%h", i, rd_valid, rd_value, csr_num);
        end
      end
    end
    @(negedge clk); #1;
    vectors++;
    if (rd_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_end rd_valid=%b exp 0", rd_valid);
    end
  endtask

  task automatic test_reset_in_drain();
    @(negedge clk);
    drive_instr(3'd0, 14'h0, 32'h0, 32'h0, 32'h1C000500, 32'h0, 5'b00010, 1'b0);
    @(negedge clk); drive_idle();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    vectors++;
    if (outs_cat !== '0) begin
      miscompares++;
      $display("FAIL drain_reset_outputs got %h exp 0", outs_cat);
    end
    @(negedge clk);
    reset = 1'b0;
    #1;
    vectors++;
    if (outs_cat !== '0 || ws_if.ws_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL drain_reset_release got %h ready %b exp 0 ready 1", outs_cat, ws_if.ws_ready);
    end
    @(negedge clk); #1;
    vectors++;
    if (outs_cat !== '0) begin
      miscompares++;
      $display("FAIL drain_reset_stray got %h exp 0", outs_cat);
    end
  endtask

  typedef struct {
    logic [31:0] pc, rj, rkd, va;
    logic [2:0]  op;
    logic [13:0] num;
    logic [4:0]  ex;
    logic        it;
  } instr_t;

  function automatic int exc_code(instr_t s);
    if (s.it)    return 'h00;
    if (s.ex[4]) return 'h08;
    if (s.ex[3]) return 'h0D;
    if (s.ex[2]) return 'h0B;
    if (s.ex[1]) return 'h0C;
    if (s.ex[0]) return 'h09;
    return -1;
  endfunction

  task automatic test_random();
    instr_t      held;
    bit          have = 0;
    int          kill = 0;
    int          kind = 0;
    int          code;
    logic [219:0] e_cat;
    logic        e_we, e_ex, e_er, e_rv, e_fr, e_ready;
    logic [13:0] e_num;
    logic [31:0] e_mask, e_wdata, e_epc, e_eaddr, e_rd, e_fpc;
    logic [5:0]  e_code;
    held = '{default: '0};
    reset = 1'b1;
    drive_idle();
    @(negedge clk);
    reset = 1'b0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      @(negedge clk);
      ws_if.ws_valid     = ($urandom_range(0, 3) != 0);
      ws_if.ws_op        = 3'($urandom_range(0, 7));
      ws_if.ws_csr_num   = 14'($urandom);
      ws_if.ws_pc        = $urandom;
      ws_if.ws_rj_value  = $urandom;
      ws_if.ws_rkd_value = $urandom;
      ws_if.ws_vaddr     = $urandom;
      ws_if.ws_ex_adef   = ($urandom_range(0, 15) == 0);
      ws_if.ws_ex_ine    = ($urandom_range(0, 15) == 0);
      ws_if.ws_ex_sys    = ($urandom_range(0, 15) == 0);
      ws_if.ws_ex_brk    = ($urandom_range(0, 15) == 0);
      ws_if.ws_ex_ale    = ($urandom_range(0, 15) == 0);
      has_int   = ($urandom_range(0, 11) == 0);
      csr_rdata = $urandom;
      era       = $urandom;
      eentry    = $urandom;
      #1;
      {e_we, e_ex, e_er, e_rv, e_fr} = '0;
      e_ready = 1'b1;
      e_num = '0; e_mask = '0; e_wdata = '0; e_epc = '0; e_eaddr = '0; e_rd = '0; e_fpc = '0; e_code = '0;
      code = exc_code(held);
      if (kill == D + 1) begin
        e_fr  = 1'b1;
        e_fpc = (kind == 1) ? eentry : era;
      end else if (have) begin
        e_num   = held.num;
        e_wdata = held.rkd;
        e_mask  = (held.op == 3'd2) ? 32'hFFFFFFFF : (held.op == 3'd3) ? held.rj : 32'h0;
        if (code >= 0) begin
          e_ex = 1'b1; e_code = 6'(code); e_epc = held.pc; e_eaddr = held.va; e_ready = 1'b0;
        end else if (held.op == 3'd4) begin
          e_er = 1'b1; e_ready = 1'b0;
        end else if (held.op >= 3'd1 && held.op <= 3'd3) begin
          e_rv = 1'b1; e_rd = csr_rdata; e_we = (held.op != 3'd1);
        end
      end
      e_cat = {e_we, e_num, e_mask, e_wdata, e_ex, e_er, e_code, 3'd0, e_epc, e_eaddr, e_rv, e_rd, e_fr, e_fpc};
      vectors++;
      if (ws_if.ws_ready !== e_ready) begin
        miscompares++;
        $display("FAIL rand_ready cyc %0d got %b exp %b", cyc, ws_if.ws_ready, e_ready);
      end
      vectors++;
      if (outs_cat !== e_cat) begin
        miscompares++;
        $display("FAIL rand_outs cyc %0d got %h exp %h", cyc, outs_cat, e_cat);
      end
      if (have && (code >= 0 || held.op == 3'd4)) begin
        kind = (code >= 0) ? 1 : 2;
        kill = D + 1;
        have = 0;
      end else if (kill > 0) begin
        kill--;
        have = 0;
      end else begin
        have = ws_if.ws_valid && e_ready;
        if (have) begin
          held.pc  = ws_if.ws_pc;   held.rj  = ws_if.ws_rj_value;
          held.rkd = ws_if.ws_rkd_value; held.va = ws_if.ws_vaddr;
          held.op  = ws_if.ws_op;   held.num = ws_if.ws_csr_num;
          held.ex  = {ws_if.ws_ex_adef, ws_if.ws_ex_ine, ws_if.ws_ex_sys, ws_if.ws_ex_brk, ws_if.ws_ex_ale};
          held.it  = has_int;
        end
      end
    end
    @(negedge clk);
    drive_idle();
    settle();
  endtask

  initial begin
    reset = 1'b1;
    drive_idle();
    csr_rdata = '0; era = '0; eentry = '0;
    test_reset();
    test_csrwr();
    test_csrxchg();
    test_syscall();
    test_priority();
    test_ertn();
    test_back_to_back();
    test_reset_in_drain();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
